pwm_ramp_sequencer: RTL

- AXI4-Lite master that programs the PWM peripheral's register file autonomously.
- On start, writes the period register once, then steps the duty register from a start value to an end value (up or down) with a programmable hold between writes.
- Provides hardware soft-start and fade without CPU involvement.
- Sits between the control logic and the PWM IP's S00_AXI slave port.

---
 rtl/pwm_ramp_sequencer_if.sv | 25 ++
 rtl/pwm_ramp_sequencer.sv | 108 ++++++++++
 2 files changed

// File: rtl/pwm_ramp_sequencer_if.sv
// pwm_ramp_sequencer_if: AXI4-Lite write-channel bundle between the ramp sequencer and the PWM slave
interface pwm_ramp_sequencer_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0]   awaddr;
    logic [2:0]          awprot;
    logic                awvalid;
    logic                awready;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wvalid;
    logic                wready;
    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;
    modport master (
        output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
        input  awready, wready, bresp, bvalid
    );
    modport slave (
        input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
        output awready, wready, bresp, bvalid
    );
endinterface

// File: rtl/pwm_ramp_sequencer.sv
// pwm_ramp_sequencer: AXI4-Lite master writing the PWM period once, then ramping duty with a hold between writes
module pwm_ramp_sequencer #(
    parameter int C_M_AXI_ADDR_WIDTH = 4,
    parameter int C_M_AXI_DATA_WIDTH = 32,
    parameter logic [C_M_AXI_ADDR_WIDTH-1:0] PERIOD_ADDR = 4'h0,
    parameter logic [C_M_AXI_ADDR_WIDTH-1:0] DUTY_ADDR   = 4'h4
) (
    input  logic        ACLK,
    input  logic        ARESETN,
    input  logic        start,
    input  logic        abort,
    input  logic [31:0] cfg_period,
    input  logic [31:0] cfg_duty_start,
    input  logic [31:0] cfg_duty_end,
    input  logic [15:0] cfg_step,
    input  logic [23:0] cfg_hold,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [31:0] cur_duty,
    pwm_ramp_sequencer_if.master m_axi
);
    typedef enum logic [2:0] {IDLE, ISSUE, RESP, HOLD, FINISH} state_t;
    state_t state_q, state_d;
    logic phase_q, phase_d, up_q, up_d, abort_q, abort_d, error_q, error_d;
    logic awvalid_q, awvalid_d, wvalid_q, wvalid_d, aw_done_q, aw_done_d, w_done_q, w_done_d;
    logic [31:0] period_q, period_d, dstart_q, dstart_d, end_q, end_d, step_q, step_d;
    logic [31:0] duty_q, duty_d, cur_q, cur_d, next_duty;
    logic [23:0] hold_q, hold_d, cnt_q, cnt_d;
    logic [C_M_AXI_ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
    logic [C_M_AXI_DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [32:0] sum;
    logic go, aw_hs, w_hs, b_hs, b_ok, enter;
    assign go    = state_q == IDLE && start && !abort;
    assign aw_hs = awvalid_q && m_axi.awready;
    assign w_hs  = wvalid_q && m_axi.wready;
    assign b_hs  = state_q == RESP && m_axi.bvalid;
    assign b_ok  = b_hs && m_axi.bresp == 2'b00;
    assign enter = state_d == ISSUE && state_q != ISSUE;
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) state_q <= IDLE;
        else          state_q <= state_d;
    end
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:   state_d = go ? ISSUE : IDLE;
            ISSUE:  state_d = ((aw_done_q || aw_hs) && (w_done_q || w_hs)) ? RESP : ISSUE;
            RESP:   state_d = !b_hs ? RESP : !b_ok ? FINISH :
                              !phase_q ? (abort_q ? FINISH : ISSUE) :
                              (duty_q == end_q || abort_q) ? FINISH : HOLD;
            HOLD:   state_d = abort_q ? FINISH : cnt_q == 24'd0 ? ISSUE : HOLD;
            default: state_d = IDLE;
        endcase
    end
    // 33-bit sum catches wrap past 0xFFFF_FFFF so the ramp clamps to the end value
    always_comb begin
        sum       = {1'b0, duty_q} + {1'b0, step_q};
        next_duty = up_q ? ((sum[32] || sum[31:0] > end_q) ? end_q : sum[31:0])
                         : ((duty_q < step_q || duty_q - step_q < end_q) ? end_q : duty_q - step_q);
        period_d  = go ? cfg_period : period_q;
        dstart_d  = go ? cfg_duty_start : dstart_q;
        end_d     = go ? cfg_duty_end : end_q;
        hold_d    = go ? cfg_hold : hold_q;
        step_d    = go ? (cfg_step == 16'd0 ? 32'd1 : {16'd0, cfg_step}) : step_q;
        up_d      = go ? cfg_duty_start <= cfg_duty_end : up_q;
        phase_d   = state_q == IDLE ? 1'b0 : (b_ok && !phase_q) ? 1'b1 : phase_q;
        duty_d    = (b_ok && !phase_q) ? dstart_q : (state_q == HOLD && cnt_q == 24'd0) ? next_duty : duty_q;
        cnt_d     = state_q == HOLD ? cnt_q - 24'd1 : hold_q;
        abort_d   = state_q == IDLE ? 1'b0 : (busy && abort) ? 1'b1 : abort_q;
        error_d   = go ? 1'b0 : (b_hs && !b_ok) ? 1'b1 : error_q;
        cur_d     = (b_ok && phase_q) ? duty_q : cur_q;
        awvalid_d = enter ? 1'b1 : awvalid_q && !m_axi.awready;
        wvalid_d  = enter ? 1'b1 : wvalid_q && !m_axi.wready;
        aw_done_d = enter ? 1'b0 : aw_done_q || aw_hs;
        w_done_d  = enter ? 1'b0 : w_done_q || w_hs;
        awaddr_d  = enter ? (phase_d ? DUTY_ADDR : PERIOD_ADDR) : awaddr_q;
        wdata_d   = enter ? (phase_d ? duty_d : period_d) : wdata_q;
    end
    always_comb begin
        busy = state_q == ISSUE || state_q == RESP || state_q == HOLD;
        done = state_q == FINISH;
    end
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            phase_q <= 1'b0; up_q <= 1'b0; abort_q <= 1'b0; error_q <= 1'b0;
            awvalid_q <= 1'b0; wvalid_q <= 1'b0; aw_done_q <= 1'b0; w_done_q <= 1'b0;
            period_q <= '0; dstart_q <= '0; end_q <= '0; step_q <= '0;
            duty_q <= '0; cur_q <= '0; hold_q <= '0; cnt_q <= '0;
            awaddr_q <= '0; wdata_q <= '0;
        end else begin
            phase_q <= phase_d; up_q <= up_d; abort_q <= abort_d; error_q <= error_d;
            awvalid_q <= awvalid_d; wvalid_q <= wvalid_d; aw_done_q <= aw_done_d; w_done_q <= w_done_d;
            period_q <= period_d; dstart_q <= dstart_d; end_q <= end_d; step_q <= step_d;
            duty_q <= duty_d; cur_q <= cur_d; hold_q <= hold_d; cnt_q <= cnt_d;
            awaddr_q <= awaddr_d; wdata_q <= wdata_d;
        end
    end
    assign error          = error_q;
    assign cur_duty       = cur_q;
    assign m_axi.awaddr   = awaddr_q;
    assign m_axi.awprot   = 3'b000;
    assign m_axi.awvalid  = awvalid_q;
    assign m_axi.wdata    = wdata_q;
    assign m_axi.wstrb    = '1;
    assign m_axi.wvalid   = wvalid_q;
    assign m_axi.bready   = state_q == RESP;
endmodule
